// File: rtl/cbfp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cbfp_pkg : shared types and helpers for the CBFP normaliser              |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package cbfp_pkg;

  typedef enum logic [0:0] {
    RD_IDLE  = 1'b0,
    RD_BURST = 1'b1
  } rd_state_t;

  localparam int CBFP_IN_W = 16;
  localparam int SHIFT_W   = $clog2(CBFP_IN_W);

  function automatic logic [31:0] sat_add_idx(input logic [31:0] idx,
                                              input logic [31:0] s,
                                              input logic [31:0] idx_max);
    logic [32:0] sum;
    sum = {1'b0, idx} + {1'b0, s};
    return (sum > {1'b0, idx_max}) ? idx_max : sum[31:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/cbfp_norm_stage_lsb_cnt.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cbfp_lsb_cnt : redundant-sign-bit count of one signed sample             |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module cbfp_lsb_cnt
  import cbfp_pkg::*;
#(
  parameter int IN_W = CBFP_IN_W,
  parameter int SH_W = SHIFT_W
) (
  input  logic signed [IN_W-1:0] x,
  output logic        [SH_W-1:0] lsb
);

  logic run;

  always_comb begin
    lsb = '0;
    run = 1'b1;
    for (int i = IN_W - 2; i >= 0; i--) begin
      if (run && (x[i] == x[IN_W-1])) begin
        lsb = lsb + SH_W'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cbfp_norm_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cbfp_norm_stage : ping-pong block-floating-point normaliser (FFT stage)  |
// | Build option    : CBFP_ROUND_EN selects round-half-up with saturation    |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
module cbfp_norm_stage
  import cbfp_pkg::*;
#(
  parameter int IN_W    = 16,
  parameter int OUT_W   = 13,
  parameter int N       = 16,
  parameter int BLK_CYC = 4,
  parameter int IDX_W   = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic signed [IN_W-1:0]  din_re  [0:N-1],
  input  logic signed [IN_W-1:0]  din_im  [0:N-1],
  input  logic        [IDX_W-1:0] idx_in  [0:N-1],
  output logic                    valid_out,
  output logic signed [OUT_W-1:0] dout_re [0:N-1],
  output logic signed [OUT_W-1:0] dout_im [0:N-1],
  output logic        [IDX_W-1:0] idx_out [0:N-1]
);

  localparam int                SH_W     = $clog2(IN_W);
  localparam int                CNT_W    = (BLK_CYC > 1) ? $clog2(BLK_CYC) : 1;
  localparam int                DROP     = IN_W - OUT_W;
  localparam logic [CNT_W-1:0]  LAST_ROW = CNT_W'(BLK_CYC - 1);
  localparam logic [SH_W-1:0]   SH_MAX   = SH_W'(IN_W - 1);
  localparam logic [31:0]       IDX_MAX  = 32'((1 << IDX_W) - 1);
`ifdef CBFP_ROUND_EN
  localparam logic signed [IN_W:0] RND   = (DROP > 0) ? ((IN_W+1)'(1) <<< (DROP - 1)) : '0;
  localparam logic signed [IN_W:0] Y_MAX = (IN_W+1)'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [IN_W:0] Y_MIN = -Y_MAX - (IN_W+1)'(1);
`endif

  // Block storage, indexed [bank][row][lane]
  logic signed [IN_W-1:0]  mem_re  [0:1][0:BLK_CYC-1][0:N-1];
  logic signed [IN_W-1:0]  mem_im  [0:1][0:BLK_CYC-1][0:N-1];
  logic        [IDX_W-1:0] mem_idx [0:1][0:BLK_CYC-1][0:N-1];

  logic [SH_W-1:0] lsb_re [0:N-1];
  logic [SH_W-1:0] lsb_im [0:N-1];

  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic             wr_bank_q, wr_bank_d;
  logic [SH_W-1:0]  run_min_q, run_min_d;
  logic [SH_W-1:0]  shift_q [0:1];
  logic [SH_W-1:0]  shift_d [0:1];
  logic [1:0]       full_q, full_d;
  rd_state_t        rd_state_q, rd_state_d;
  logic             rd_bank_q, rd_bank_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic             valid_out_q, valid_out_d;
  logic signed [OUT_W-1:0] dout_re_q [0:N-1];
  logic signed [OUT_W-1:0] dout_re_d [0:N-1];
  logic signed [OUT_W-1:0] dout_im_q [0:N-1];
  logic signed [OUT_W-1:0] dout_im_d [0:N-1];
  logic        [IDX_W-1:0] idx_out_q [0:N-1];
  logic        [IDX_W-1:0] idx_out_d [0:N-1];

  logic             wr_done;
  logic [SH_W-1:0]  blk_min;
  logic             emit;
  logic             fresh;
  logic [CNT_W-1:0] row;
  logic [SH_W-1:0]  sh_sel;
  logic signed [IN_W-1:0]  src_re;
  logic signed [IN_W-1:0]  src_im;
  logic        [IDX_W-1:0] src_idx;

  for (genvar k = 0; k < N; k++) begin : g_lane
    cbfp_lsb_cnt #(.IN_W(IN_W), .SH_W(SH_W)) u_lsb_re (.x(din_re[k]), .lsb(lsb_re[k]));
    cbfp_lsb_cnt #(.IN_W(IN_W), .SH_W(SH_W)) u_lsb_im (.x(din_im[k]), .lsb(lsb_im[k]));
  end

  function automatic logic signed [OUT_W-1:0] scale(input logic signed [IN_W-1:0] x,
                                                    input logic        [SH_W-1:0] s);
    logic signed [IN_W:0] w;
    w = (IN_W+1)'(x);
    w = w <<< s;
`ifdef CBFP_ROUND_EN
    w = (w + RND) >>> DROP;
    if (w > Y_MAX) begin
      w = Y_MAX;
    end else if (w < Y_MIN) begin
      w = Y_MIN;
    end
`else
    w = w >>> DROP;
`endif
    return OUT_W'(w);
  endfunction

  always_ff @(posedge clk) begin
    if (valid_in) begin
      mem_re[wr_bank_q][wr_cnt_q]  <= din_re;
      mem_im[wr_bank_q][wr_cnt_q]  <= din_im;
      mem_idx[wr_bank_q][wr_cnt_q] <= idx_in;
    end
  end

  always_comb begin
    wr_cnt_d    = wr_cnt_q;
    wr_bank_d   = wr_bank_q;
    run_min_d   = run_min_q;
    shift_d     = shift_q;
    full_d      = full_q;
    rd_state_d  = rd_state_q;
    rd_bank_d   = rd_bank_q;
    rd_cnt_d    = rd_cnt_q;
    valid_out_d = 1'b0;
    dout_re_d   = dout_re_q;
    dout_im_d   = dout_im_q;
    idx_out_d   = idx_out_q;
    emit        = 1'b0;
    row         = rd_cnt_q;
    src_re      = '0;
    src_im      = '0;
    src_idx     = '0;

    blk_min = (wr_cnt_q == '0) ? SH_MAX : run_min_q;
    for (int k = 0; k < N; k++) begin
      if (lsb_re[k] < blk_min) blk_min = lsb_re[k];
      if (lsb_im[k] < blk_min) blk_min = lsb_im[k];
    end

    wr_done = valid_in && (wr_cnt_q == LAST_ROW);
    if (valid_in) begin
      run_min_d = blk_min;
      if (wr_done) begin
        wr_cnt_d           = '0;
        wr_bank_d          = ~wr_bank_q;
        shift_d[wr_bank_q] = blk_min;
        full_d[wr_bank_q]  = 1'b1;
      end else begin
        wr_cnt_d = wr_cnt_q + CNT_W'(1);
      end
    end

    // A block completing this cycle starts its burst at once, so its shift
    // (and, for single-beat blocks, its data) bypass the bank registers.
    case (rd_state_q)
      RD_IDLE: begin
        if (full_q[rd_bank_q] || (wr_done && (wr_bank_q == rd_bank_q))) begin
          emit = 1'b1;
          row  = '0;
        end
      end
      RD_BURST: emit = 1'b1;
      default:  rd_state_d = RD_IDLE;
    endcase

    fresh  = !full_q[rd_bank_q];
    sh_sel = fresh ? blk_min : shift_q[rd_bank_q];

    if (emit) begin
      valid_out_d = 1'b1;
      for (int k = 0; k < N; k++) begin
        if (fresh && (row == wr_cnt_q)) begin
          src_re  = din_re[k];
          src_im  = din_im[k];
          src_idx = idx_in[k];
        end else begin
          src_re  = mem_re[rd_bank_q][row][k];
          src_im  = mem_im[rd_bank_q][row][k];
          src_idx = mem_idx[rd_bank_q][row][k];
        end
        dout_re_d[k] = scale(src_re, sh_sel);
        dout_im_d[k] = scale(src_im, sh_sel);
        idx_out_d[k] = IDX_W'(sat_add_idx(32'(src_idx), 32'(sh_sel), IDX_MAX));
      end
      if (row == LAST_ROW) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
        rd_cnt_d          = '0;
        rd_state_d        = full_d[~rd_bank_q] ? RD_BURST : RD_IDLE;
      end else begin
        rd_cnt_d   = row + CNT_W'(1);
        rd_state_d = RD_BURST;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt_q    <= '0;
      wr_bank_q   <= 1'b0;
      run_min_q   <= SH_MAX;
      shift_q     <= '{default: '0};
      full_q      <= '0;
      rd_state_q  <= RD_IDLE;
      rd_bank_q   <= 1'b0;
      rd_cnt_q    <= '0;
      valid_out_q <= 1'b0;
      dout_re_q   <= '{default: '0};
      dout_im_q   <= '{default: '0};
      idx_out_q   <= '{default: '0};
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      wr_bank_q   <= wr_bank_d;
      run_min_q   <= run_min_d;
      shift_q     <= shift_d;
      full_q      <= full_d;
      rd_state_q  <= rd_state_d;
      rd_bank_q   <= rd_bank_d;
      rd_cnt_q    <= rd_cnt_d;
      valid_out_q <= valid_out_d;
      dout_re_q   <= dout_re_d;
      dout_im_q   <= dout_im_d;
      idx_out_q   <= idx_out_d;
    end
  end

  assign valid_out = valid_out_q;
  assign dout_re   = dout_re_q;
  assign dout_im   = dout_im_q;
  assign idx_out   = idx_out_q;

endmodule
`default_nettype wire
